// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and default sizes for the multi-channel PWM.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    localparam int c_default_channels = 4;
    localparam int c_default_width    = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM output: active duty register, comparator, output flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = c_default_width
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_count,
    output logic             o_pwm
);

    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;

    // Compare uses the duty active during this count; a load takes effect
    // together with the counter restart at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty <= i_duty;
            end
            r_pwm <= i_enable && (i_count < r_duty);
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : Multi-channel edge/center-aligned PWM with shadowed duty load.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CHANNELS = c_default_channels,
    parameter int WIDTH    = c_default_width
)(
    input  logic                      CLK,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      sample_req,
    output logic                      underrun
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]          r_count;
    cnt_dir_e                  r_dir;
    logic [WIDTH-1:0]          r_period;
    pwm_mode_e                 r_mode;
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic                      r_shadow_full;
    logic                      r_underrun;

    logic [WIDTH-1:0]          w_count_nxt;
    cnt_dir_e                  w_dir_nxt;
    logic                      w_terminal;
    logic                      w_boundary;
    logic                      w_transfer;
    logic                      w_load;

    // Terminal cycle: last cycle of the current period under the active setup.
    always_comb begin
        w_terminal = 1'b0;
        if (r_period == '0) begin
            w_terminal = 1'b1;
        end else if ((r_mode == PWM_EDGE) || (r_period == c_one)) begin
            w_terminal = (r_count == r_period);
        end else begin
            w_terminal = (r_dir == CNT_DOWN) && (r_count == c_one);
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (!enable || w_terminal) begin
            w_count_nxt = '0;
            w_dir_nxt   = CNT_UP;
        end else if (r_mode == PWM_EDGE) begin
            w_count_nxt = r_count + c_one;
        end else if (r_dir == CNT_UP) begin
            if (r_count == r_period) begin
                w_count_nxt = r_count - c_one;
                w_dir_nxt   = CNT_DOWN;
            end else begin
                w_count_nxt = r_count + c_one;
            end
        end else begin
            w_count_nxt = r_count - c_one;
        end
    end

    // While disabled every edge acts as a boundary so re-enable starts fresh.
    assign w_boundary = !enable || w_terminal;
    assign w_transfer = duty_valid && !r_shadow_full;
    assign w_load     = r_shadow_full && w_boundary;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_dir         <= CNT_UP;
            r_period      <= '0;
            r_mode        <= PWM_EDGE;
            r_shadow      <= '0;
            r_shadow_full <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            if (w_boundary) begin
                r_period <= period;
                r_mode   <= pwm_mode_e'(mode);
            end
            if (w_transfer) begin
                r_shadow      <= duty_in;
                r_shadow_full <= 1'b1;
            end else if (w_load) begin
                r_shadow_full <= 1'b0;
            end
            r_underrun <= enable && w_terminal && !r_shadow_full;
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk      (CLK),
                .rst_n    (reset_n),
                .i_enable (enable),
                .i_load   (w_load),
                .i_duty   (r_shadow[g*WIDTH +: WIDTH]),
                .i_count  (r_count),
                .o_pwm    (pwm_out[g])
            );
        end
    endgenerate

    assign duty_ready = !r_shadow_full;
    // Gated by reset_n so the request drops immediately while reset is held.
    assign sample_req = reset_n && enable && (r_count == '0);
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_gen
// Description : Directed scoreboard bench for pwm_multi_gen (4 ch, 8 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        mode;
    logic [7:0]  period;
    logic [31:0] duty_in;
    logic        duty_valid;
    logic        duty_ready;
    logic [3:0]  pwm_out;
    logic        sample_req;
    logic        underrun;

    pwm_multi_gen #(
        .CHANNELS (4),
        .WIDTH    (8)
    ) dut (
        .CLK        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .period     (period),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .pwm_out    (pwm_out),
        .sample_req (sample_req),
        .underrun   (underrun)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pwm;
        logic       sreq;
        logic       urun;
        logic       rdy;
        logic [3:0] mask;   // {pwm, sreq, urun, rdy}
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    // Duty sets, channel 0 in the low byte.
    localparam logic [31:0] c_d0 = {8'd255, 8'd10, 8'd3, 8'd0};
    localparam logic [31:0] c_w1 = {8'd0,   8'd9,  8'd5, 8'd1};
    localparam logic [31:0] c_w2 = {8'd10,  8'd0,  8'd7, 8'd2};
    localparam logic [31:0] c_dc = {8'd4,   8'd5,  8'd0, 8'd2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            if (me.mask[3]) begin
                checks++;
                if (pwm_out !== me.pwm) begin
                    errors++;
                    $display("FAIL %s cyc %0d pwm_out got %b want %b", me.tag, cyc, pwm_out, me.pwm);
                end
            end
            if (me.mask[2]) begin
                checks++;
                if (sample_req !== me.sreq) begin
                    errors++;
                    $display("FAIL %s cyc %0d sample_req got %b want %b", me.tag, cyc, sample_req, me.sreq);
                end
            end
            if (me.mask[1]) begin
                checks++;
                if (underrun !== me.urun) begin
                    errors++;
                    $display("FAIL %s cyc %0d underrun got %b want %b", me.tag, cyc, underrun, me.urun);
                end
            end
            if (me.mask[0]) begin
                checks++;
                if (duty_ready !== me.rdy) begin
                    errors++;
                    $display("FAIL %s cyc %0d duty_ready got %b want %b", me.tag, cyc, duty_ready, me.rdy);
                end
            end
        end
        if (stim_done && q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never reached, want 0", q.size());
            q.delete();
        end
    end

    function automatic logic [3:0] cmp(input int c, input logic [31:0] d);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (c < int'(d[i*8 +: 8]));
        return r;
    endfunction

    // Center-aligned count at cycle m of a run with period P (period 2P).
    function automatic int cen(input int m, input int p);
        int t;
        t = m % (2 * p);
        return (t <= p) ? t : 2 * p - t;
    endfunction

    task automatic push(input logic [3:0] pwm, input logic sreq, input logic urun,
                        input logic rdy, input logic [3:0] mask, input string tag);
        exp_t e;
        e.cyc = cyc; e.pwm = pwm; e.sreq = sreq; e.urun = urun;
        e.rdy = rdy; e.mask = mask; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two disabled cycles: transfer a word into the shadow, then let it load.
    task automatic load_disabled(input logic [31:0] d, input logic [7:0] p, input logic m);
        enable = 1'b0; period = p; mode = m; duty_in = d; duty_valid = 1'b1;
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b0101, "dis_load0");
        tick();
        duty_valid = 1'b0;
        push(4'b0, 1'b0, 1'b0, 1'b0, 4'b1111, "dis_load1");
        tick();
    endtask

    function automatic int edge_cnt(input int m);
        return (m < 60) ? (m % 10) : ((m - 60) % 5);
    endfunction

    function automatic logic [31:0] edge_duty(input int m);
        return (m < 40) ? c_d0 : (m < 50) ? c_w1 : c_w2;
    endfunction

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 1'b0; period = 8'd9;
        duty_in = '0; duty_valid = 1'b0;
        tick();
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "reset");
        tick();
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "reset");
        tick();
        reset_n = 1'b1;

        // Edge mode P=9: duties, handshake stall, underrun, period change.
        load_disabled(c_d0, 8'd9, 1'b0);
        for (int n = 0; n < 75; n++) begin
            logic [3:0] ep;
            logic       ur;
            logic       rd;
            enable     = 1'b1;
            period     = (n < 56) ? 8'd9 : 8'd4;
            duty_valid = (n >= 32) && (n <= 40);
            duty_in    = (n == 32) ? c_w1 : c_w2;
            ep = (n >= 1) ? cmp(edge_cnt(n - 1), edge_duty(n - 1)) : 4'b0;
            ur = (n >= 10) && (edge_cnt(n) == 0) && (n != 40) && (n != 50);
            rd = !(((n >= 33) && (n <= 39)) || ((n >= 41) && (n <= 49)));
            push(ep, edge_cnt(n) == 0, ur, rd, 4'b1111, "edge");
            tick();
        end
        duty_valid = 1'b0;

        // Center mode P=4 with a mid-period disable and re-enable.
        load_disabled(c_dc, 8'd4, 1'b1);
        for (int n = 0; n < 28; n++) begin
            int k;
            enable     = !((n == 13) || (n == 14));
            duty_valid = (n == 26);
            duty_in    = c_d0;
            if (n == 13) begin
                push(cmp(cen(12, 4), c_dc), 1'b0, 1'b0, 1'b1, 4'b1111, "disable");
            end else if (n == 14) begin
                push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "disabled");
            end else begin
                k = (n < 13) ? n : n - 15;
                push((k >= 1) ? cmp(cen(k - 1, 4), c_dc) : 4'b0, (k % 8) == 0,
                     (k >= 8) && ((k % 8) == 0), n != 27, 4'b1111, "center");
            end
            tick();
        end
        duty_valid = 1'b0;

        // Asynchronous reset while outputs are high and the shadow is full.
        reset_n = 1'b0;
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "async_reset");
        tick();
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "async_reset");
        reset_n = 1'b1;
        enable  = 1'b0;
        tick();
        push(4'b0, 1'b0, 1'b0, 1'b1, 4'b1111, "post_reset");
        tick();
        tick();
        stim_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Parametrised multi-channel PWM generator for the DRFM board. It drives `CHANNELS` PWM outputs from one shared period counter, and runs in either edge-aligned or center-aligned (up/down) mode. Duty words arrive from the SDRAM read path through a valid/ready handshake into a shadow register. The shadow contents move to the active set only at a period boundary, so duty changes never cause glitches. It replaces the fixed 8-bit, single-channel, free-running PWM loop in the top level, and adds a per-period sample request and an underrun indication.

## Interface
- `CHANNELS`, 4, number of PWM outputs
- `WIDTH`, 8, bit width of the counter, period and each duty word
- `CLK`  in  1  system clock (M100CLK domain); all logic is on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run the counter; when low, the counter is held and the outputs are forced low
- `mode`  in  1  0 = edge-aligned, 1 = center-aligned; latched at each boundary
- `period`  in  WIDTH  terminal count; latched at each boundary
- `duty_in`  in  CHANNELS*WIDTH  duty words; channel i uses bits [i*WIDTH +: WIDTH]
- `duty_valid`  in  1  upstream presents `duty_in`
- `duty_ready`  out  1  shadow register is empty
- `pwm_out`  out  CHANNELS  registered PWM outputs
- `sample_req`  out  1  one-cycle pulse at the start of each period
- `underrun`  out  1  one-cycle pulse when a boundary finds the shadow empty

## Operation
- **Reset values:** count=0, dir=up, active duty=0, active period=0, active mode=edge, shadow_full=0.
- **Output reset values:** `duty_ready`=1, `pwm_out`=0, `sample_req`=0, `underrun`=0.
- **Handshake:**
  - `duty_ready` = !shadow_full.
  - A transfer occurs when `duty_valid` && `duty_ready`. It loads the shadow and sets shadow_full.
  - Upstream must hold `duty_in` stable until the transfer.
- **Edge mode:**
  - The counter runs 0..P, where P is the active period, then wraps to 0.
  - Period length is P+1 cycles.
  - The terminal cycle is count==P.
- **Center mode:**
  - The counter counts up 0..P, then down P-1..1, then returns to 0.
  - Period length is 2P cycles.
  - The terminal cycle is the down-count at 1, or count==P when P==1.
  - P==0 means the counter stays at 0 and every cycle is terminal (both modes).
- **Boundary (clock edge ending a terminal cycle, `enable`=1):**
  - Latch `period` and `mode` into the active registers.
  - If shadow_full: copy shadow to active duty and clear shadow_full.
  - If the shadow is empty: pulse `underrun` in the next cycle and keep the active duty.
  - A transfer accepted in the terminal cycle itself lands in the shadow and applies at the next boundary. That boundary still reports an underrun.
- **Compare:** `pwm_out[i]` <= (enable && count < duty[i]).
  - duty=0 gives a constant low output.
  - duty>P (edge) or duty>P (center) gives a constant high output.
- **`sample_req`:** high in every enabled cycle with count==0. It asks upstream for the next duty word.
- **`enable` low:**
  - Next edge: count=0, dir=up, `pwm_out`=0.
  - No `underrun` or `sample_req` pulses.
  - Every edge latches `period`/`mode` and moves a full shadow into active, so re-enabling starts with the latest values.
- **Arithmetic:** count and comparisons are unsigned WIDTH-bit. The counter never exceeds P, so there is no wrap beyond P.

## Timing
- `pwm_out` has one cycle of latency from the count value it reflects.
- `duty_ready` falls on the edge after a transfer and rises on the edge after the boundary that empties the shadow.
- `sample_req` is asserted in the first enabled cycle with count==0, including the first cycle after `enable` rises.
- `underrun` is asserted in the cycle after the terminal cycle, which is the same cycle as `sample_req`.
- Asserting `reset_n` low clears all state and outputs immediately (asynchronously), including mid-period. Deassertion is synchronised externally.

## Structure
- Package `pwm_pkg` holds:
  - the mode enum (`PWM_EDGE`, `PWM_CENTER`)
  - the direction enum (`CNT_UP`, `CNT_DOWN`)
  - the defaults for `CHANNELS` and `WIDTH`
- Sub-module `pwm_channel`, one instance per channel, generated in a loop. It contains the active duty register, the comparator and the registered output. It takes count, enable and load strobe from the shared counter.
- The counter, direction, boundary detection and shadow handshake live in `pwm_multi_gen`.

## Test plan
- **Edge mode duties:** WIDTH=8, CHANNELS=4, edge mode, P=9.
  - Stimulus: load duties {0,3,10,255} while disabled, then enable.
  - Response: ch0 always low; ch1 high for 3 of every 10 cycles; ch2 and ch3 always high; `sample_req` every 10 cycles.
- **Center mode:** center mode, P=4, duty=2.
  - Response: count sequence 0,1,2,3,4,3,2,1 repeating.
  - Response: `pwm_out` high 3 of 8 cycles, centred on count 0; `sample_req` every 8 cycles.
- **Handshake stall:**
  - Stimulus: two `duty_valid` words within one period.
  - Response: the first is accepted and `duty_ready` falls; the second stalls until the cycle after the boundary and then applies one period later.
- **Underrun:**
  - Stimulus: no transfer during an enabled period.
  - Response: `underrun` pulses once, coincident with `sample_req`, and the duties are unchanged.
- **Period change:**
  - Stimulus: change `period` from 9 to 4 at count 6.
  - Response: the current period completes to 9, then 5-cycle periods follow.
- **Disable and reset:**
  - Stimulus: drop `enable` mid-period.
  - Response: `pwm_out`=0 next cycle; on re-enable, `sample_req` appears in the first cycle.
  - Stimulus: pulse `reset_n` low mid-period.
  - Response: all outputs 0 and `duty_ready`=1 without waiting for a clock edge.
